// File: rtl/udm_uart_rx.sv
// UDM UART receive front-end: rx synchronizer, 8N1 deframer, one-entry valid/ready holding register.
// Optional UDM_UART_RX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module udm_uart_rx #(
    parameter int DIV_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UDM_UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev_q;
    logic                   fall;
    logic                   tick;

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_in;
    logic [DIV_WIDTH-1:0]   half_in;
    logic [DIV_WIDTH-1:0]   full_per;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   par_bad;

`ifdef UDM_UART_RX_PARITY_EN
    logic                   perr_q, perr_d;
    assign par_bad = perr_q;
`else
    assign par_bad = 1'b0;
`endif

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign fall     = rx_prev_q & ~rx_s;
    assign tick     = (cnt_q == '0);
    assign div_in   = (clk_div_i < DIV_MIN) ? DIV_MIN : clk_div_i;
    assign half_in  = (div_in >> 1) - ONE;
    assign full_per = div_q - ONE;

    // Flops reset high so a released reset never looks like a start edge.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
            rx_prev_q <= rx_s;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= S_IDLE;
            div_q   <= DIV_MIN;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UDM_UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UDM_UART_RX_PARITY_EN
        perr_d  = perr_q;
`endif

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (!tick) begin
            cnt_d = cnt_q - ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    div_d   = div_in;
                    cnt_d   = half_in;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        cnt_d   = full_per;
                        bit_d   = 3'd0;
                        state_d = S_DATA;
`ifdef UDM_UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = full_per;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UDM_UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UDM_UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    perr_d  = rx_s ^ (^shift_q);
                    cnt_d   = full_per;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_IDLE;
                        if (par_bad) begin
                            ferr_d = 1'b1;
                        end else if (!valid_q || ready_i) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_udm_uart_rx.sv
// Directed bench for udm_uart_rx: line-history UART model checked every cycle,
// plus literal expectations for latency, pulse counts and received bytes.
module tb_udm_uart_rx;

    localparam int S  = 2;
    localparam int DW = 16;
    localparam int NL = 8192;
`ifdef UDM_UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clk    = 1'b0;
    logic          arst_n = 1'b0;
    logic          rx     = 1'b1;
    logic          ready  = 1'b0;
    logic [DW-1:0] div    = 16'd16;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          frame_err_o;
    logic          overrun_o;
    logic          busy_o;

    udm_uart_rx #(
        .DIV_WIDTH  (DW),
        .SYNC_STAGES(S)
    ) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .rx_i       (rx),
        .clk_div_i  (div),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: line[c] is the rx level the bench drove during cycle c.
    bit         line [NL];
    bit         m_act = 1'b0;
    bit         m_brk = 1'b0;
    int         m_f, m_base, m_d, m_h;
    logic       e_valid = 1'b0;
    logic       e_ferr  = 1'b0;
    logic       e_ovr   = 1'b0;
    logic       e_busy  = 1'b0;
    logic [7:0] e_data  = 8'h00;

    int   n_vrise = 0;
    int   t_vrise = 0;
    int   n_ferr  = 0;
    int   n_ovr   = 0;
    int   n_busy  = 0;
    logic v_prev  = 1'b0;

    initial foreach (line[i]) line[i] = 1'b1;

    task automatic model_step(input int c);
        logic       n_valid, n_fe, n_ov, st, pb;
        logic [7:0] b, n_data;
        n_valid = e_valid & ~ready;
        n_data  = e_data;
        n_fe    = 1'b0;
        n_ov    = 1'b0;
        b       = 8'h00;
        if (m_act) begin
            if (c == m_base + m_h && line[m_f + m_h]) begin
                m_act = 1'b0;
            end else if (c == m_base + m_h + (9 + PAR) * m_d) begin
                for (int i = 0; i < 8; i++) b[i] = line[m_f + m_h + (i + 1) * m_d];
                pb = (PAR == 1) ? ((^b) ^ line[m_f + m_h + 9 * m_d]) : 1'b0;
                st = line[m_f + m_h + (9 + PAR) * m_d];
                m_act = 1'b0;
                if (!st) begin
                    n_fe  = 1'b1;
                    m_brk = 1'b1;
                end else if (pb) begin
                    n_fe = 1'b1;
                end else if (!e_valid || ready) begin
                    n_valid = 1'b1;
                    n_data  = b;
                end else begin
                    n_ov = 1'b1;
                end
            end
        end else if (m_brk) begin
            if (line[c - S]) m_brk = 1'b0;
        end else if (c > S && !line[c - S] && line[c - S - 1]) begin
            m_act  = 1'b1;
            m_base = c;
            m_f    = c - S;
            m_d    = (div < 4) ? 4 : int'(div);
            m_h    = m_d / 2;
        end
        e_valid = n_valid;
        e_data  = n_data;
        e_ferr  = n_fe;
        e_ovr   = n_ov;
        e_busy  = m_act | m_brk;
    endtask

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (c < NL) line[c] = rx;
        if (!arst_n) begin
            for (int k = 0; k <= S; k++) if (c >= k && c - k < NL) line[c - k] = 1'b1;
            m_act   = 1'b0;
            m_brk   = 1'b0;
            e_valid = 1'b0;
            e_data  = 8'h00;
            e_ferr  = 1'b0;
            e_ovr   = 1'b0;
            e_busy  = 1'b0;
        end
        chk("valid_o", 32'(valid_o), 32'(e_valid));
        chk("data_o", 32'(data_o), 32'(e_data));
        chk("frame_err_o", 32'(frame_err_o), 32'(e_ferr));
        chk("overrun_o", 32'(overrun_o), 32'(e_ovr));
        chk("busy_o", 32'(busy_o), 32'(e_busy));
        if (valid_o && !v_prev) begin
            n_vrise++;
            t_vrise = c;
        end
        v_prev = valid_o;
        n_ferr += 32'(frame_err_o);
        n_ovr  += 32'(overrun_o);
        n_busy += 32'(busy_o);
        if (arst_n) model_step(c);
    end

    task automatic send(input logic [7:0] b, input bit stop = 1'b1,
                        input bit pflip = 1'b0, input int nslots = 32);
        logic [10:0] fr;
        int          d;
        d  = (div < 4) ? 4 : int'(div);
        fr = '1;
        fr[0]       = 1'b0;
        fr[8:1]     = b;
        fr[9 + PAR] = stop;
        if (PAR == 1) fr[9] = (^b) ^ pflip;
        for (int i = 0; i < 10 + PAR && i < nslots; i++) begin
            rx = fr[i];
            step(d);
        end
    endtask

    initial begin
        int t0, v0, f0, o0, b0;
        step(4);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ferr", 32'(frame_err_o), 0);
        chk("rst_ovr", 32'(overrun_o), 0);
        arst_n = 1'b1;
        step(5);

        // basic byte, latency, hold while not ready
        div = 16'd16;
        ready = 1'b0;
        v0 = n_vrise;
        t0 = cyc;
        send(8'hA5);
        chk("t1_latency", t_vrise - t0, 155 + 16 * PAR);
        chk("t1_data", 32'(data_o), 32'hA5);
        step(20);
        chk("t1_hold_valid", 32'(valid_o), 1);
        chk("t1_hold_data", 32'(data_o), 32'hA5);
        ready = 1'b1;
        step(1);
        chk("t1_drain", 32'(valid_o), 0);
        ready = 1'b0;
        chk("t1_vrise", n_vrise - v0, 1);

        // start-bit glitch
        step(5);
        v0 = n_vrise;
        f0 = n_ferr;
        b0 = n_busy;
        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(40);
        chk("t2_busy_cycles", n_busy - b0, 8);
        chk("t2_novalid", n_vrise - v0, 0);
        chk("t2_noferr", n_ferr - f0, 0);

        // bad stop bit, held-low line, then recovery
        f0 = n_ferr;
        v0 = n_vrise;
        send(8'h3C, 1'b0);
        step(100);
        chk("t3_busy_break", 32'(busy_o), 1);
        rx = 1'b1;
        step(40);
        chk("t3_busy_idle", 32'(busy_o), 0);
        chk("t3_ferr", n_ferr - f0, 1);
        chk("t3_novalid", n_vrise - v0, 0);
        send(8'h55);
        step(5);
        chk("t3_next_data", 32'(data_o), 32'h55);
        chk("t3_next_valid", 32'(valid_o), 1);
        ready = 1'b1;
        step(1);
        ready = 1'b0;

        // overrun with consumer stalled
        o0 = n_ovr;
        v0 = n_vrise;
        send(8'h11);
        send(8'h22);
        step(20);
        chk("t4_data", 32'(data_o), 32'h11);
        chk("t4_valid", 32'(valid_o), 1);
        chk("t4_ovr", n_ovr - o0, 1);
        chk("t4_vrise", n_vrise - v0, 1);
        ready = 1'b1;
        step(1);

        // minimum divisor, back-to-back
        div = 16'd4;
        step(4);
        o0 = n_ovr;
        v0 = n_vrise;
        send(8'h00);
        send(8'hFF);
        send(8'h80);
        step(10);
        chk("t5_vrise", n_vrise - v0, 3);
        chk("t5_ovr", n_ovr - o0, 0);
        chk("t5_last", 32'(data_o), 32'h80);

        // divisor below 4 clamps; mid-frame change ignored
        div = 16'd1;
        v0 = n_vrise;
        fork
            send(8'h5A);
            begin
                step(10);
                div = 16'd40;
            end
        join
        step(10);
        chk("t5b_data", 32'(data_o), 32'h5A);
        chk("t5b_vrise", n_vrise - v0, 1);
        div = 16'd16;
        step(4);

        // reset mid-DATA
        v0 = n_vrise;
        f0 = n_ferr;
        send(8'h7E, 1'b1, 1'b0, 4);
        rx = 1'b1;
        arst_n = 1'b0;
        step(1);
        chk("t6_rst_busy", 32'(busy_o), 0);
        chk("t6_rst_valid", 32'(valid_o), 0);
        chk("t6_rst_data", 32'(data_o), 0);
        step(1);
        arst_n = 1'b1;
        step(40);
        chk("t6_quiet", (n_vrise - v0) + (n_ferr - f0), 0);
        send(8'h7E);
        step(5);
        chk("t6_data", 32'(data_o), 32'h7E);
        chk("t6_vrise", n_vrise - v0, 1);

`ifdef UDM_UART_RX_PARITY_EN
        f0 = n_ferr;
        v0 = n_vrise;
        send(8'h07, 1'b1, 1'b1);
        step(10);
        chk("par_ferr", n_ferr - f0, 1);
        chk("par_novalid", n_vrise - v0, 0);
        send(8'h07);
        step(10);
        chk("par_data", 32'(data_o), 32'h07);
        chk("par_vrise", n_vrise - v0, 1);
`endif

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/udm_uart_rx.md
Name: udm_uart_rx

Overview:
- Serial receive front-end of the UART debug path.
- Sits between the board/bench rx line and the UDM command decoder.
- Synchronizes the asynchronous rx line and detects/validates start bits.
- Deframes 8N1 bytes at a runtime-programmable bit period.
- Delivers each byte through a one-entry valid/ready holding register, with frame-error and overrun reporting.

Parameters:
- DIV_WIDTH, 16, width of the clk_div_i bit-period input.
- SYNC_STAGES, 2, flops in the rx synchronizer (allowed range 2..4).

Ports:
- clk_i  input  1  system clock.
- arst_n_i  input  1  asynchronous active-low reset.
- rx_i  input  1  asynchronous serial line; idle high.
- clk_div_i  input  DIV_WIDTH  clock cycles per bit; values below 4 are treated as 4.
- data_o  output  8  received byte; stable while valid_o is high.
- valid_o  output  1  byte available.
- ready_i  input  1  consumer accepts; transfer occurs when valid_o && ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface (already decided): one clock, clk_i. Reset arst_n_i is asynchronous and active-low.
- Reset values:
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, FSM=IDLE.
  - Synchronizer flops reset to 1, so no false start at reset release.
- rx_s is the synchronized rx_i, SYNC_STAGES flops deep. All decisions use rx_s.
- clk_div_i is latched into div_q on start detection. Changes mid-frame have no effect on the current frame.
- The bit counter is a down-counter, cnt, loaded with div_q-1 (one bit period) or (div_q>>1)-1 (half period). A "tick" is cnt==0.
- FSM:
  - IDLE: on rx_s falling edge (previous 1, current 0), latch div_q, load half period -> START.
  - START: on tick, if rx_s==0 load full period, bit index=0 -> DATA; else (glitch) -> IDLE with no outputs.
  - DATA: on tick, shift rx_s into shift register LSB-first and reload full period. When bit index reaches 7 -> STOP (or -> PARITY when the optional feature is built).
  - STOP: on tick, if rx_s==1 deliver the byte and -> IDLE. If rx_s==0, pulse frame_err_o, discard the byte, -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. Prevents re-triggering on a held-low line.
- Delivery, evaluated in the cycle after the stop-bit tick:
  - Register empty, or being drained this cycle (valid_o && ready_i): load data_o, valid_o=1. No overrun.
  - Register full and not drained: pulse overrun_o, drop the new byte; data_o keeps the old byte.
- valid_o deasserts the cycle after a handshake unless a new byte loads that same cycle.
- Timing:
  - Stop sample point = 9.5 bit periods after the synchronized falling edge.
  - valid_o rises 1 cycle after that point.
  - Total from rx_i edge ≈ SYNC_STAGES + 9.5·div_q + 1 cycles.
- Frame error and overrun are mutually exclusive per frame. Both are single-cycle pulses, never sticky.
- Reset mid-frame: all state clears asynchronously. The partial byte is lost and no pulse is emitted after release.

Optional Feature:
- Macro: UDM_UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA: one extra bit period, even parity over the 8 data bits plus the parity bit.
  - On mismatch the byte is discarded and frame_err_o pulses at the stop tick.
  - The stop-bit check is unchanged.
- Not defined: pure 8N1; no PARITY state exists and no parity logic is synthesized.

Test Plan:
1. clk_div_i=16, send 8N1 byte 0xA5 on rx_i -> valid_o rises ~155 cycles after the start edge, data_o=0xA5; hold ready_i=0 for 20 cycles -> data_o/valid_o stable; ready_i=1 -> valid_o low next cycle.
2. rx_i low pulse of 3 cycles, clk_div_i=16 -> returns to IDLE, no valid_o, no frame_err_o, busy_o high for ≤8 cycles only.
3. Send 0x3C with stop bit=0, then hold rx_i low 100 cycles, then high -> one frame_err_o pulse, no valid_o, busy_o stays high until rx_i returns high; next byte 0x55 received correctly.
4. ready_i=0, send 0x11 then 0x22 back-to-back -> first valid_o with 0x11, one overrun_o pulse at end of the second frame, data_o still 0x11.
5. ready_i held 1, bytes 0x00,0xFF,0x80 back-to-back at clk_div_i=4 -> three valid_o pulses with matching data, no overrun_o.
6. Assert arst_n_i for 2 cycles mid-DATA of 0x7E, release -> all outputs 0, busy_o=0; subsequent 0x7E received correctly. With UDM_UART_RX_PARITY_EN: 0x07 with parity bit=0 -> frame_err_o; parity bit=1 -> valid_o, data_o=0x07.
